// File: rtl/reg_scoreboard_if.sv
// Decode/writeback signal bundle for the register scoreboard.
// master = pipeline control side, slave = scoreboard.
interface reg_scoreboard_if;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_jal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_used;
    logic        rt_used;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [31:0] busy;
    logic        err;

    modport master (
        output issue_valid, issue_rd, issue_jal, rs, rt, rs_used, rt_used,
        output wb_valid, wb_rd, flush,
        input  stall, busy, err
    );

    modport slave (
        input  issue_valid, issue_rd, issue_jal, rs, rt, rs_used, rt_used,
        input  wb_valid, wb_rd, flush,
        output stall, busy, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register in-flight writer counters for the MIPS decode stage; raises a
// zero-latency stall on unforwardable RAW hazards and on counter saturation.
module reg_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter bit          WB_BYPASS    = 1'b1
) (
    input logic             clk,
    input logic             reset,
    reg_scoreboard_if.slave sb
);
    localparam logic [1:0] MAX_CNT = 2'(MAX_INFLIGHT);

    logic [1:0]  count_q [32];
    logic [1:0]  count_d [32];
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic        err_q;
    logic        err_d;

    logic [4:0]  dst;
    logic        rs_busy;
    logic        rt_busy;
    logic        full_block;
    logic        stall_c;
    logic        accept;

    // Entry 0 is held at zero so r0 reads as never busy without special-casing indices.
    always_comb begin
        dst        = sb.issue_jal ? 5'd31 : sb.issue_rd;
        rs_busy    = (sb.rs != '0) && (count_q[sb.rs] != '0) &&
                     !(WB_BYPASS && sb.wb_valid && (sb.wb_rd == sb.rs) && (count_q[sb.rs] == 2'd1));
        rt_busy    = (sb.rt != '0) && (count_q[sb.rt] != '0) &&
                     !(WB_BYPASS && sb.wb_valid && (sb.wb_rd == sb.rt) && (count_q[sb.rt] == 2'd1));
        full_block = sb.issue_valid && (dst != '0) && (count_q[dst] == MAX_CNT) &&
                     !(sb.wb_valid && (sb.wb_rd == dst));
        stall_c    = (sb.rs_used && rs_busy) || (sb.rt_used && rt_busy) || full_block;
        accept     = sb.issue_valid && !stall_c;
    end

    always_comb begin
        err_d = err_q;
        if (sb.wb_valid && (sb.wb_rd != '0) && (count_q[sb.wb_rd] == '0)) begin
            err_d = 1'b1;
        end
        for (int unsigned r = 0; r < 32; r++) begin
            logic inc;
            logic dec;
            inc        = accept && (dst == 5'(r)) && (r != 0);
            dec        = sb.wb_valid && (sb.wb_rd == 5'(r)) && (count_q[r] != '0);
            count_d[r] = count_q[r];
            if (sb.flush || (r == 0)) begin
                count_d[r] = '0;
            end else if (inc && !dec) begin
                count_d[r] = count_q[r] + 2'd1;
            end else if (dec && !inc) begin
                count_d[r] = count_q[r] - 2'd1;
            end
            busy_d[r] = (count_q[r] != '0);
        end
    end

    // busy is sampled from the current counts, so it trails them by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '{default: '0};
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign sb.stall = stall_c;
    assign sb.busy  = busy_q;
    assign sb.err   = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized self-checking bench for reg_scoreboard against a behavioural
// per-register counter model, plus directed scenarios with literal expectations.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic reset;

    reg_scoreboard_if sb();

    reg_scoreboard #(
        .MAX_INFLIGHT(3),
        .WB_BYPASS   (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sb)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          m_cnt[32] = '{default: 0};
    logic [31:0] m_busy = '0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_dst();
        return sb.issue_jal ? 31 : int'(sb.issue_rd);
    endfunction

    function automatic bit m_src_busy(input int r);
        if (r == 0 || m_cnt[r] == 0) return 1'b0;
        if (sb.wb_valid && int'(sb.wb_rd) == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        int d;
        d = m_dst();
        if (sb.rs_used && m_src_busy(int'(sb.rs))) return 1'b1;
        if (sb.rt_used && m_src_busy(int'(sb.rt))) return 1'b1;
        if (sb.issue_valid && d != 0 && m_cnt[d] == 3 && !(sb.wb_valid && int'(sb.wb_rd) == d)) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: plain counters updated with the architectural rules.
    always @(posedge clk or negedge reset) begin
        bit acc;
        bit dec_ok;
        int d;
        int w;
        if (!reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_busy = '0;
            m_err  = 1'b0;
        end else begin
            acc    = sb.issue_valid && !m_stall();
            d      = m_dst();
            w      = int'(sb.wb_rd);
            dec_ok = sb.wb_valid && w != 0 && m_cnt[w] > 0;
            for (int i = 0; i < 32; i++) m_busy[i] = (m_cnt[i] != 0);
            if (sb.wb_valid && w != 0 && m_cnt[w] == 0) m_err = 1'b1;
            if (sb.flush) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end else begin
                if (acc && d != 0) m_cnt[d] = m_cnt[d] + 1;
                if (dec_ok) m_cnt[w] = m_cnt[w] - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("stall", {31'd0, sb.stall}, {31'd0, m_stall()});
        chk("busy", sb.busy, m_busy);
        chk("err", {31'd0, sb.err}, {31'd0, m_err});
    end

    task automatic drive(input logic iv, input logic [4:0] rd, input logic jal,
                         input logic [4:0] rs_, input logic [4:0] rt_, input logic rsu,
                         input logic rtu, input logic wv, input logic [4:0] wrd, input logic fl);
        sb.issue_valid = iv;
        sb.issue_rd    = rd;
        sb.issue_jal   = jal;
        sb.rs          = rs_;
        sb.rt          = rt_;
        sb.rs_used     = rsu;
        sb.rt_used     = rtu;
        sb.wb_valid    = wv;
        sb.wb_rd       = wrd;
        sb.flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 5));
    endfunction

    initial begin
        int pend[$];
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", sb.busy, 32'd0);
        chk("rst_err", {31'd0, sb.err}, 32'd0);
        chk("rst_stall", {31'd0, sb.stall}, 32'd0);
        reset = 1'b1;

        // RAW on r8 with writeback bypass
        drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t1_accept", {31'd0, sb.stall}, 32'd0);
        tick(); drive(0, 0, 0, 8, 0, 1, 0, 0, 0, 0); #1;
        chk("t1_raw_stall", {31'd0, sb.stall}, 32'd1);
        chk("t1_busy_lag", {31'd0, sb.busy[8]}, 32'd0);
        tick(); drive(0, 0, 0, 8, 0, 1, 0, 1, 8, 0); #1;
        chk("t1_bypass", {31'd0, sb.stall}, 32'd0);
        chk("t1_busy8", {31'd0, sb.busy[8]}, 32'd1);
        tick(); drive(0, 0, 0, 8, 0, 1, 0, 0, 0, 0); #1;
        chk("t1_cleared", {31'd0, sb.stall}, 32'd0);
        chk("t1_model8", m_cnt[8], 32'd0);

        // jal forces r31
        tick(); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        tick(); drive(1, 6, 0, 0, 31, 0, 1, 0, 0, 0); #1;
        chk("t2_rt31_stall", {31'd0, sb.stall}, 32'd1);
        chk("t2_model31", m_cnt[31], 32'd1);
        chk("t2_model5", m_cnt[5], 32'd0);
        drive(1, 6, 0, 0, 31, 0, 0, 0, 0, 0); #1;
        chk("t2_rt_unused", {31'd0, sb.stall}, 32'd0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 31, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
        tick(); idle();

        // saturation at three writers on r9
        repeat (3) begin
            drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t3_full_stall", {31'd0, sb.stall}, 32'd1);
        tick();
        chk("t3_model9_a", m_cnt[9], 32'd3);
        drive(1, 9, 0, 0, 0, 0, 0, 1, 9, 0); #1;
        chk("t3_full_wb", {31'd0, sb.stall}, 32'd0);
        tick();
        chk("t3_model9_b", m_cnt[9], 32'd3);
        chk("t3_busy9", {31'd0, sb.busy[9]}, 32'd1);
        repeat (3) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
            tick();
        end

        // r0 never busy; bad retire sets sticky err
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); #1;
        chk("t4_r0_stall", {31'd0, sb.stall}, 32'd0);
        tick(); idle(); tick();
        chk("t4_busy0", sb.busy, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        tick(); idle();
        chk("t4_err", {31'd0, sb.err}, 32'd1);
        tick(); tick();
        chk("t4_err_sticky", {31'd0, sb.err}, 32'd1);

        // flush overrides a simultaneous issue
        drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t5_model4", m_cnt[4], 32'd2);
        drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        idle();
        chk("t5_model4_flushed", m_cnt[4], 32'd0);
        chk("t5_model7_flushed", m_cnt[7], 32'd0);
        tick();
        chk("t5_busy", sb.busy, 32'd0);
        chk("t5_err_held", {31'd0, sb.err}, 32'd1);

        // asynchronous reset between edges
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 3, 0, 1, 0, 0, 0, 0); #1;
        chk("t6_pre_stall", {31'd0, sb.stall}, 32'd1);
        chk("t6_pre_busy3", {31'd0, sb.busy[3]}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_busy", sb.busy, 32'd0);
        chk("t6_rst_stall", {31'd0, sb.stall}, 32'd0);
        tick();
        reset = 1'b1;
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t6_model3", m_cnt[3], 32'd1);
        chk("t6_err_cleared", {31'd0, sb.err}, 32'd0);
        drive(0, 0, 0, 3, 0, 1, 0, 0, 0, 0); #1;
        chk("t6_post_stall", {31'd0, sb.stall}, 32'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                #1 reset = 1'b1;
            end
            pend.delete();
            for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) pend.push_back(r);
            sb.issue_valid = 1'($urandom_range(0, 1));
            sb.issue_rd    = pick();
            sb.issue_jal   = ($urandom_range(0, 9) == 0);
            sb.rs          = pick();
            sb.rt          = pick();
            sb.rs_used     = 1'($urandom_range(0, 1));
            sb.rt_used     = 1'($urandom_range(0, 1));
            sb.wb_valid    = ($urandom_range(0, 2) != 0);
            if (pend.size() != 0 && $urandom_range(0, 9) != 0)
                sb.wb_rd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                sb.wb_rd = pick();
            sb.flush       = ($urandom_range(0, 49) == 0);
        end
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
